// File: rtl/mem_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single-port memory, one transaction at a time.
// Default arbitration is round-robin. Defining MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module mem_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int AW         = 5,
  parameter int DW         = 8,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [DW-1:0]         rdata,
  output logic                  busy,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_data_in,
  input  logic [DW-1:0]         mem_data_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        rrPtr_q, rrPtr_d;
  logic [CW-1:0]        latCnt_q, latCnt_d;
  logic [IW-1:0]        winIdx_q, winIdx_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic                 busy_q, busy_d;
  logic                 memRead_q, memRead_d;
  logic                 memWrite_q, memWrite_d;
  logic [AW-1:0]        memAddr_q, memAddr_d;
  logic [DW-1:0]        memDataIn_q, memDataIn_d;

  logic                 anyReq;
  logic [IW-1:0]        winSel;
  int                   searchStart;
  int                   idx;

  // Winner search: first requesting index at or after the start point, wrapping around.
  always_comb begin
    anyReq = 1'b0;
    winSel = '0;
    idx    = 0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    searchStart = 0;
`else
    searchStart = int'(rrPtr_q);
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!anyReq) begin
        idx = searchStart + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (req[idx]) begin
          anyReq = 1'b1;
          winSel = IW'(idx);
        end
      end
    end
  end

  // Outputs are computed one cycle ahead so that they are all registered.
  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    latCnt_d    = latCnt_q;
    winIdx_d    = winIdx_q;
    gnt_d       = '0;
    done_d      = '0;
    rdata_d     = rdata_q;
    memRead_d   = 1'b0;
    memWrite_d  = 1'b0;
    memAddr_d   = memAddr_q;
    memDataIn_d = memDataIn_q;

    case (state_q)
      IDLE: begin
        if (anyReq) begin
          winIdx_d       = winSel;
          gnt_d[winSel]  = 1'b1;
          memAddr_d      = req_addr[winSel*AW +: AW];
          memDataIn_d    = req_wdata[winSel*DW +: DW];
          if (req_we[winSel]) begin
            memWrite_d     = 1'b1;
            done_d[winSel] = 1'b1;
          end else begin
            memRead_d = 1'b1;
          end
`ifndef MEM_ARB_FIXED_PRIO_EN
          if (winSel == IW'(NUM_REQ-1)) rrPtr_d = '0;
          else                          rrPtr_d = winSel + 1'b1;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (memWrite_q) begin
          state_d = IDLE;
        end else begin
          latCnt_d = CW'(MEM_RD_LAT);
          state_d  = RDWAIT;
        end
      end
      RDWAIT: begin
        latCnt_d = latCnt_q - 1'b1;
        if (latCnt_q == CW'(1)) begin
          rdata_d          = mem_data_out;
          done_d[winIdx_q] = 1'b1;
          state_d          = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      latCnt_q    <= '0;
      winIdx_q    <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      memRead_q   <= 1'b0;
      memWrite_q  <= 1'b0;
      memAddr_q   <= '0;
      memDataIn_q <= '0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      latCnt_q    <= latCnt_d;
      winIdx_q    <= winIdx_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      memRead_q   <= memRead_d;
      memWrite_q  <= memWrite_d;
      memAddr_q   <= memAddr_d;
      memDataIn_q <= memDataIn_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign mem_read    = memRead_q;
  assign mem_write   = memWrite_q;
  assign mem_addr    = memAddr_q;
  assign mem_data_in = memDataIn_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates NUM_REQ independent requesters onto the single-port memory's read/write/addr/data_in/data_out bus.
- Sits between the test/bus-master side and the memory instance in the top-level.
- Serialises one transaction at a time.
- Handles the memory's read latency, returns read data to the winning requester and signals completion.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
AW, 5, memory address width
DW, 8, memory data width
MEM_RD_LAT, 1, clocks from mem_read asserted until mem_data_out valid (1..4)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request, level
req_we  input  NUM_REQ  per-requester 1=write 0=read
req_addr  input  NUM_REQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata  input  NUM_REQ*DW  packed write data, requester i at [i*DW +: DW]
gnt  output  NUM_REQ  one-hot grant, one-cycle pulse
done  output  NUM_REQ  one-hot completion, one-cycle pulse
rdata  output  DW  read data of last completed read
busy  output  1  transaction in flight (state != IDLE)
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  AW  memory address
mem_data_in  output  DW  memory write data
mem_data_out  input  DW  memory read data

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. All outputs and state are registered.
- Reset values: gnt=0, done=0, rdata=0, busy=0, mem_read=0, mem_write=0, mem_addr=0, mem_data_in=0. State=IDLE, rr_ptr=0, lat_cnt=0.
- FSM states: IDLE, ISSUE, RDWAIT, DONE.
- IDLE:
  - If any req bit is set, select the winner and latch its we/addr/wdata and index. Go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt[win]=1; mem_addr and mem_data_in driven from the latch.
  - Write: mem_write=1, done[win]=1 in this same cycle, next state IDLE.
  - Read: mem_read=1, lat_cnt loaded with MEM_RD_LAT, next state RDWAIT.
- RDWAIT:
  - mem_read=0; lat_cnt decrements each cycle.
  - When lat_cnt reaches 1, capture mem_data_out into rdata and go to DONE.
- DONE (1 cycle): done[win]=1, rdata valid. Next state IDLE.
- rdata holds its value until the next read completes. Writes never change rdata.
- Latency from req sampled in IDLE:
  - Write: gnt/done at +1 cycle.
  - Read: gnt at +1 cycle, done at +2+MEM_RD_LAT cycles.
  - Minimum spacing between transactions is 2 cycles (write) and 3+MEM_RD_LAT cycles (read).
- Arbitration (default) is round-robin:
  - Search starts at index rr_ptr and wraps modulo NUM_REQ.
  - On each grant, rr_ptr = win+1, wrapping NUM_REQ-1 -> 0.
- Handshake rules:
  - A requester holds req/we/addr/wdata stable until it sees gnt.
  - It must drop req in the cycle after gnt, or a new transaction is arbitrated.
  - req is sampled only in IDLE. A req dropped after latching does not cancel the transaction.
- Simultaneous requests: exactly one winner. The others remain pending with no loss.
- mem_read and mem_write are never asserted together, and never outside ISSUE.
- Reset mid-operation: immediate return to reset values. The in-flight transaction is abandoned with no done pulse. The requester re-requests.
- busy=1 in ISSUE, RDWAIT and DONE.

Optional Feature:
- Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest index requesting always wins; rr_ptr is unused and held at 0.
- Undefined: round-robin as above.
- Timing, FSM and handshake are identical in both modes.

Test Plan:
1. Hold rst_n=0 for 3 clocks with random inputs -> all outputs 0; after release, busy=0 with no req.
2. Requester 0 writes addr 5 data 0xA5, then reads addr 5 (MEM_RD_LAT=1) -> gnt[0] at +1 each time; write done at +1; read done at +3 with rdata=0xA5.
3. Requesters 0 and 1 hold continuous writes to addrs 1 and 2 for 8 grants (round-robin) -> gnt sequence 0,1,0,1,0,1,0,1; mem_write never overlaps mem_read.
4. MEM_RD_LAT=3, read of addr 31 preloaded with 0x3C -> done at +5 after sampling, rdata=0x3C; rdata unchanged by a subsequent write.
5. Pull rst_n low during RDWAIT of a read -> outputs clear asynchronously, no done pulse; the next write from requester 1 completes normally.
6. With MEM_ARB_FIXED_PRIO_EN, requesters 0 and 1 both continuous -> gnt always 0; requester 1 is granted only after requester 0 drops req.
